// File: rtl/rgb2ycrcb_pipe.sv
// Three-stage pipelined RGB -> YCrCb converter with valid/ready handshake,
// line-last sideband and runtime-selectable cosited 4:2:2 chroma decimation.
module rgb2ycrcb_pipe #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 10,
    parameter int COEF_W = 11,
    parameter int K_R    = 306,
    parameter int K_G    = 601,
    parameter int K_B    = 117,
    parameter int K_CR   = 730,
    parameter int K_CB   = 578
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3*DATA_W-1:0]   in_rgb,
    input  logic                  in_last,
    input  logic                  mode_422,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3*DATA_W-1:0]   out_ycc,
    output logic                  out_last
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int YSUM_W = DATA_W + COEF_W + 2;
    localparam int D_W    = DATA_W + 1;
    localparam int C_W    = DATA_W + COEF_W + 3;

    localparam logic [DATA_W-1:0]     MAX_V = '1;
    localparam logic signed [C_W-1:0] KCR_S = C_W'(K_CR);
    localparam logic signed [C_W-1:0] KCB_S = C_W'(K_CB);
    localparam logic signed [C_W-1:0] C_OFS = C_W'(2 ** (DATA_W - 1)) << FRAC_W;

    // Chroma: negative clamps to zero, otherwise truncate and saturate high.
    function automatic logic [DATA_W-1:0] csat(input logic signed [C_W-1:0] c);
        logic [C_W-1:0] sh;
        sh = $unsigned(c) >> FRAC_W;
        if (c < 0)                    return '0;
        else if (sh > C_W'(MAX_V))    return MAX_V;
        else                          return sh[DATA_W-1:0];
    endfunction

    logic                     v1_q, v1_d, last1_q, last1_d, m1_q, m1_d;
    logic [PROD_W-1:0]        pr_q, pr_d, pg_q, pg_d, pb_q, pb_d;
    logic [DATA_W-1:0]        r1_q, r1_d, b1_q, b1_d;
    logic                     v2_q, v2_d, last2_q, last2_d, m2_q, m2_d;
    logic [DATA_W-1:0]        y2_q, y2_d;
    logic signed [D_W-1:0]    dr2_q, dr2_d, db2_q, db2_d;
    logic                     v3_q, v3_d, last3_q, last3_d, m3_q, m3_d;
    logic [DATA_W-1:0]        y3_q, y3_d, cr3_q, cr3_d, cb3_q, cb3_d;
    logic                     phase_q, phase_d;
    logic [DATA_W-1:0]        crl_q, crl_d;

    logic                     en, out_xfer;
    logic [DATA_W-1:0]        r_in, g_in, b_in, y_sat, chroma;
    logic [YSUM_W-1:0]        ysum, yshift;
    logic signed [D_W-1:0]    dr, db;
    logic signed [C_W-1:0]    cr_c, cb_c;

    always_comb begin
        v1_d = v1_q; last1_d = last1_q; m1_d = m1_q;
        pr_d = pr_q; pg_d = pg_q; pb_d = pb_q; r1_d = r1_q; b1_d = b1_q;
        v2_d = v2_q; last2_d = last2_q; m2_d = m2_q;
        y2_d = y2_q; dr2_d = dr2_q; db2_d = db2_q;
        v3_d = v3_q; last3_d = last3_q; m3_d = m3_q;
        y3_d = y3_q; cr3_d = cr3_q; cb3_d = cb3_q;
        phase_d = phase_q; crl_d = crl_q;

        r_in = in_rgb[3*DATA_W-1 -: DATA_W];
        g_in = in_rgb[2*DATA_W-1 -: DATA_W];
        b_in = in_rgb[DATA_W-1:0];

        en       = !v3_q || out_ready;
        out_xfer = v3_q && out_ready;

        ysum   = YSUM_W'(pr_q) + YSUM_W'(pg_q) + YSUM_W'(pb_q);
        yshift = ysum >> FRAC_W;
        y_sat  = (yshift > YSUM_W'(MAX_V)) ? MAX_V : yshift[DATA_W-1:0];
        dr     = $signed({1'b0, r1_q}) - $signed({1'b0, y_sat});
        db     = $signed({1'b0, b1_q}) - $signed({1'b0, y_sat});

        cr_c = C_W'(dr2_q) * KCR_S + C_OFS;
        cb_c = C_W'(db2_q) * KCB_S + C_OFS;

        if (en) begin
            v1_d    = in_valid;
            last1_d = in_last;
            m1_d    = mode_422;
            pr_d    = PROD_W'(K_R) * PROD_W'(r_in);
            pg_d    = PROD_W'(K_G) * PROD_W'(g_in);
            pb_d    = PROD_W'(K_B) * PROD_W'(b_in);
            r1_d    = r_in;
            b1_d    = b_in;

            v2_d    = v1_q;
            last2_d = last1_q;
            m2_d    = m1_q;
            y2_d    = y_sat;
            dr2_d   = dr;
            db2_d   = db;

            v3_d    = v2_q;
            last3_d = last2_q;
            m3_d    = m2_q;
            y3_d    = y2_q;
            cr3_d   = csat(cr_c);
            cb3_d   = csat(cb_c);
        end

        // Phase advances only on 4:2:2 beats; line end or a 4:4:4 beat restarts it.
        if (out_xfer) begin
            phase_d = m3_q && !last3_q && !phase_q;
            if (m3_q && !phase_q)
                crl_d = cr3_q;
        end

        chroma    = phase_q ? crl_q : cb3_q;
        in_ready  = en;
        out_valid = v3_q;
        out_last  = last3_q;
        out_ycc   = m3_q ? {y3_q, chroma, {DATA_W{1'b0}}} : {y3_q, cr3_q, cb3_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0; last1_q <= 1'b0; m1_q <= 1'b0;
            pr_q <= '0; pg_q <= '0; pb_q <= '0; r1_q <= '0; b1_q <= '0;
            v2_q <= 1'b0; last2_q <= 1'b0; m2_q <= 1'b0;
            y2_q <= '0; dr2_q <= '0; db2_q <= '0;
            v3_q <= 1'b0; last3_q <= 1'b0; m3_q <= 1'b0;
            y3_q <= '0; cr3_q <= '0; cb3_q <= '0;
            phase_q <= 1'b0; crl_q <= '0;
        end else begin
            v1_q <= v1_d; last1_q <= last1_d; m1_q <= m1_d;
            pr_q <= pr_d; pg_q <= pg_d; pb_q <= pb_d; r1_q <= r1_d; b1_q <= b1_d;
            v2_q <= v2_d; last2_q <= last2_d; m2_q <= m2_d;
            y2_q <= y2_d; dr2_q <= dr2_d; db2_q <= db2_d;
            v3_q <= v3_d; last3_q <= last3_d; m3_q <= m3_d;
            y3_q <= y3_d; cr3_q <= cr3_d; cb3_q <= cb3_d;
            phase_q <= phase_d; crl_q <= crl_d;
        end
    end

endmodule

// File: tb/tb_rgb2ycrcb_pipe.sv
// Directed bench for rgb2ycrcb_pipe: vector table, backpressure, 4:2:2
// phasing, coefficient override and mid-stream reset.
module tb_rgb2ycrcb_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_valid2, in_last, mode_422, out_ready;
    logic [23:0] in_rgb;
    logic        in_ready, out_valid, out_last;
    logic [23:0] out_ycc;
    logic        in_ready2, out_valid2, out_last2;
    logic [23:0] out_ycc2;

    int checks = 0;
    int errors = 0;

    logic [24:0] exp_q[$];
    logic [24:0] exp2_q[$];

    typedef struct {
        logic [23:0] rgb;
        logic        last;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    rgb2ycrcb_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rgb(in_rgb), .in_last(in_last), .mode_422(mode_422),
        .out_valid(out_valid), .out_ready(out_ready), .out_ycc(out_ycc),
        .out_last(out_last)
    );

    rgb2ycrcb_pipe #(.K_CR(1500)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_rgb(in_rgb), .in_last(in_last), .mode_422(mode_422),
        .out_valid(out_valid2), .out_ready(out_ready), .out_ycc(out_ycc2),
        .out_last(out_last2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every output transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [24:0] e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL out_unexpected: got %0h expected none", out_ycc);
            end else begin
                e = exp_q.pop_front();
                chk("out_ycc", {8'h0, out_ycc}, {8'h0, e[23:0]});
                chk("out_last", {31'h0, out_last}, {31'h0, e[24]});
            end
        end
        if (!rst && out_valid2 && out_ready) begin
            if (exp2_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL out2_unexpected: got %0h expected none", out_ycc2);
            end else begin
                e = exp2_q.pop_front();
                chk("out2_ycc", {8'h0, out_ycc2}, {8'h0, e[23:0]});
                chk("out2_last", {31'h0, out_last2}, {31'h0, e[24]});
            end
        end
    end

    task automatic send(input logic [23:0] rgb, input logic lst, input logic m,
                        input logic [23:0] ex, input logic to2, input logic [23:0] ex2);
        int  n;
        logic ok;
        n = 0;
        in_rgb = rgb; in_last = lst; mode_422 = m;
        in_valid = 1'b1; in_valid2 = to2;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 60);
        if (ok) begin
            exp_q.push_back({lst, ex});
            if (to2) exp2_q.push_back({lst, ex2});
        end else begin
            checks++; errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 60 cycles");
        end
        in_valid = 1'b0; in_valid2 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp2_q.size() != 0) && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_outstanding", exp_q.size() + exp2_q.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish before 300us");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] hold;

        vecs[0] = '{24'h000000, 1'b0, 24'h008080};
        vecs[1] = '{24'hFFFFFF, 1'b0, 24'hFF8080};
        vecs[2] = '{24'hFF0000, 1'b0, 24'h4CFF55};
        vecs[3] = '{24'h00FF00, 1'b0, 24'h95152B};
        vecs[4] = '{24'h0000FF, 1'b1, 24'h1D6BFF};
        vecs[5] = '{24'h808080, 1'b0, 24'h808080};
        vecs[6] = '{24'h6432C8, 1'b0, 24'h528CC2};
        vecs[7] = '{24'h0AC81E, 1'b1, 24'h7B2F4B};

        rst = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0; in_last = 1'b0;
        mode_422 = 1'b0; out_ready = 1'b1; in_rgb = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'h0, out_valid}, 0);
        chk("rst_out_ycc", {8'h0, out_ycc}, 0);
        chk("rst_out_last", {31'h0, out_last}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {31'h0, in_ready}, 1);

        // Latency: valid appears in the third cycle after the transfer cycle.
        send(vecs[0].rgb, 1'b0, 1'b0, vecs[0].exp, 1'b0, '0);
        @(negedge clk); chk("lat_c1", {31'h0, out_valid}, 0);
        @(negedge clk); chk("lat_c2", {31'h0, out_valid}, 0);
        @(negedge clk); chk("lat_c3", {31'h0, out_valid}, 1);
        drain();

        // Full-rate stream of the vector table.
        for (int i = 0; i < 8; i++)
            send(vecs[i].rgb, vecs[i].last, 1'b0, vecs[i].exp, 1'b0, '0);
        drain();

        // Same stream with a 5-cycle downstream stall in the middle.
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(vecs[i].rgb, vecs[i].last, 1'b0, vecs[i].exp, 1'b0, '0);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                hold = '0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (k == 0) hold = out_ycc;
                    else chk("stall_ycc_stable", {8'h0, out_ycc}, {8'h0, hold});
                    chk("stall_out_valid", {31'h0, out_valid}, 1);
                    chk("stall_in_ready", {31'h0, in_ready}, 0);
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        drain();

        // K_CR override: red clamps high, green clamps to zero.
        send(24'hFF0000, 1'b0, 1'b0, 24'h4CFF55, 1'b1, 24'h4CFF55);
        send(24'h00FF00, 1'b1, 1'b0, 24'h95152B, 1'b1, 24'h95002B);
        drain();

        // 4:2:2 odd-length line, then phase-0 start of the next line.
        send(24'hFF0000, 1'b0, 1'b1, 24'h4C5500, 1'b0, '0);
        send(24'h0000FF, 1'b0, 1'b1, 24'h1DFF00, 1'b0, '0);
        send(24'hFF0000, 1'b0, 1'b1, 24'h4C5500, 1'b0, '0);
        send(24'h0000FF, 1'b0, 1'b1, 24'h1DFF00, 1'b0, '0);
        send(24'hFF0000, 1'b1, 1'b1, 24'h4C5500, 1'b0, '0);
        send(24'h00FF00, 1'b0, 1'b1, 24'h952B00, 1'b0, '0);
        // A 4:4:4 beat in between also returns the phase to 0.
        send(24'h0000FF, 1'b0, 1'b0, 24'h1D6BFF, 1'b0, '0);
        send(24'h00FF00, 1'b1, 1'b1, 24'h952B00, 1'b0, '0);
        drain();

        // Reset with three pixels in flight and the output stalled.
        out_ready = 1'b0;
        send(vecs[2].rgb, 1'b0, 1'b0, vecs[2].exp, 1'b0, '0);
        send(vecs[3].rgb, 1'b0, 1'b0, vecs[3].exp, 1'b0, '0);
        send(vecs[4].rgb, 1'b0, 1'b0, vecs[4].exp, 1'b0, '0);
        @(negedge clk);
        chk("full_out_valid", {31'h0, out_valid}, 1);
        chk("full_in_ready", {31'h0, in_ready}, 0);
        #1 rst = 1'b1;
        #1;
        chk("midrst_out_valid", {31'h0, out_valid}, 0);
        chk("midrst_out_ycc", {8'h0, out_ycc}, 0);
        exp_q.delete();
        exp2_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("postrst_in_ready", {31'h0, in_ready}, 1);
        send(vecs[6].rgb, 1'b1, 1'b0, vecs[6].exp, 1'b0, '0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
